// File: rtl/ah_snoop_admit_stage.sv
// Admission stage in front of the snoopable request FIFO: one request in flight,
// snooped by key before push, held back while the key is already queued.
module ah_snoop_admit_stage #(
  parameter int DATA_W    = 132,
  parameter int KEY_W     = 16,
  parameter int RETRY_GAP = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [KEY_W-1:0]  sdata_o,
  output logic              svalid_o,
  input  logic              smatch_i,
  output logic              hazard_timeout_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int TO_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_CHECK,
    S_WAIT,
    S_PUSH
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [15:0]         stall_q, stall_d;
  logic                hto_q, hto_d;
  logic                hazard;
  logic                to_hit;

  assign to_hit = (to_q == TO_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    to_d    = to_q;
    stall_d = stall_q;
    hto_d   = 1'b0;
    hazard  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          hold_d  = in_data_i;
          to_d    = '0;
          state_d = S_SNOOP;
        end
      end
      S_SNOOP: state_d = S_CHECK;
      S_CHECK: begin
        if (smatch_i) begin
          hazard = 1'b1;
          if (to_hit) begin
            hto_d   = 1'b1;
            state_d = S_PUSH;
          end else begin
            gap_d   = GAP_W'(RETRY_GAP - 1);
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_PUSH;
        end
      end
      S_WAIT: begin
        hazard = 1'b1;
        // Timeout wins over the retry gap so the stall bound is exact.
        if (to_hit) begin
          hto_d   = 1'b1;
          state_d = S_PUSH;
        end else if (gap_q == '0) begin
          state_d = S_SNOOP;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_PUSH: begin
        if (wready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (hazard) begin
      to_d = to_q + TO_W'(1);
      if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      stall_q <= '0;
      hto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      stall_q <= stall_d;
      hto_q   <= hto_d;
    end
  end

  // Data buses are zeroed outside their strobe so a stale hold never leaks out.
  assign in_ready_o       = (state_q == S_IDLE);
  assign svalid_o         = (state_q == S_SNOOP);
  assign sdata_o          = svalid_o ? hold_q[KEY_W-1:0] : '0;
  assign wvalid_o         = (state_q == S_PUSH);
  assign wdata_o          = wvalid_o ? hold_q : '0;
  assign hazard_timeout_o = hto_q;
  assign stall_cnt_o      = stall_q;

endmodule

// File: tb/tb_ah_snoop_admit_stage.sv
// Directed bench for ah_snoop_admit_stage; cycle 0 is the cycle a request is accepted.
module tb_ah_snoop_admit_stage;

  localparam int DATA_W = 132;
  localparam int KEY_W  = 16;

  logic              clk;
  logic              rstn;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [KEY_W-1:0]  sdata;
  logic              svalid;
  logic              smatch;
  logic              hazard_timeout;
  logic [15:0]       stall_cnt;

  int vectors = 0;
  int errors  = 0;

  localparam logic [DATA_W-1:0] D1 = 132'hA_5A5A_1234_5678_9ABC_DEF0_0BAD_CAFE_00AB;
  localparam logic [DATA_W-1:0] D4 = 132'h3_0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [DATA_W-1:0] D5 = 132'hF_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_1234;

  ah_snoop_admit_stage #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .RETRY_GAP(4), .TIMEOUT(255)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .wdata_o(wdata), .wvalid_o(wvalid), .wready_i(wready),
    .sdata_o(sdata), .svalid_o(svalid), .smatch_i(smatch),
    .hazard_timeout_o(hazard_timeout), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; smatch = 1'b0; wready = 1'b1;
    tick; tick;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; smatch = 1'b0; wready = 1'b1;
    tick;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", wvalid); end
    vectors++; if (wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata); end
    vectors++; if (svalid !== 1'b0) begin errors++; $display("FAIL reset_svalid got %b exp 0", svalid); end
    vectors++; if (sdata !== '0) begin errors++; $display("FAIL reset_sdata got %h exp 0", sdata); end
    vectors++; if (hazard_timeout !== 1'b0) begin errors++; $display("FAIL reset_hto got %b exp 0", hazard_timeout); end
    vectors++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
    rstn = 1'b1;
  endtask

  task automatic test_no_hazard;
    do_reset;
    in_data = D1; in_valid = 1'b1; smatch = 1'b0; wready = 1'b1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nh_ready_c0 got %b exp 1", in_ready); end
    tick; in_valid = 1'b0; in_data = '0;
    vectors++; if (svalid !== 1'b1) begin errors++; $display("FAIL nh_svalid_c1 got %b exp 1", svalid); end
    vectors++; if (sdata !== 16'h00AB) begin errors++; $display("FAIL nh_sdata_c1 got %h exp 00ab", sdata); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nh_ready_c1 got %b exp 0", in_ready); end
    tick;
    vectors++; if (svalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL nh_c2 got sv=%b wv=%b exp 0 0", svalid, wvalid); end
    tick;
    vectors++; if (wvalid !== 1'b1) begin errors++; $display("FAIL nh_wvalid_c3 got %b exp 1", wvalid); end
    vectors++; if (wdata !== D1) begin errors++; $display("FAIL nh_wdata_c3 got %h exp %h", wdata, D1); end
    tick;
    vectors++; if (in_ready !== 1'b1 || wvalid !== 1'b0) begin errors++; $display("FAIL nh_c4 got rdy=%b wv=%b exp 1 0", in_ready, wvalid); end
    vectors++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL nh_stall got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_one_hazard;
    int nsv, sv2, wv1, rdy;
    nsv = 0; sv2 = -1; wv1 = -1; rdy = -1;
    do_reset;
    in_data = D1; in_valid = 1'b1; smatch = 1'b0; wready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick; in_valid = 1'b0;
      if (svalid) begin nsv++; if (nsv == 2) sv2 = c; end
      if (wvalid && wv1 < 0) wv1 = c;
      if (in_ready && rdy < 0) rdy = c;
      smatch = (nsv == 1);
    end
    vectors++; if (sv2 !== 7) begin errors++; $display("FAIL oh_svalid2 got %0d exp 7", sv2); end
    vectors++; if (wv1 !== 9) begin errors++; $display("FAIL oh_wvalid got %0d exp 9", wv1); end
    vectors++; if (rdy !== 10) begin errors++; $display("FAIL oh_ready got %0d exp 10", rdy); end
    vectors++; if (nsv !== 2) begin errors++; $display("FAIL oh_nsnoop got %0d exp 2", nsv); end
    vectors++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL oh_stall got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_timeout;
    int wv1, hto_c, hto_n;
    wv1 = -1; hto_c = -1; hto_n = 0;
    do_reset;
    in_data = D4; in_valid = 1'b1; smatch = 1'b1; wready = 1'b1;
    for (int c = 1; c <= 320; c++) begin
      tick; in_valid = 1'b0;
      if (wvalid && wv1 < 0) wv1 = c;
      if (hazard_timeout) begin hto_n++; hto_c = c; end
    end
    vectors++; if (hto_n !== 1) begin errors++; $display("FAIL to_pulses got %0d exp 1", hto_n); end
    vectors++; if (hto_c !== 309) begin errors++; $display("FAIL to_pulse_cycle got %0d exp 309", hto_c); end
    vectors++; if (wv1 !== 309) begin errors++; $display("FAIL to_wvalid_cycle got %0d exp 309", wv1); end
    vectors++; if (stall_cnt !== 16'd256) begin errors++; $display("FAIL to_stall got %0d exp 256", stall_cnt); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL to_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_backpressure;
    do_reset;
    in_data = D4; in_valid = 1'b1; smatch = 1'b0; wready = 1'b0;
    tick; in_valid = 1'b0; in_data = '0;
    tick; tick;
    for (int c = 3; c <= 12; c++) begin
      vectors++; if (wvalid !== 1'b1 || wdata !== D4) begin errors++; $display("FAIL bp_hold c%0d got wv=%b wd=%h exp 1 %h", c, wvalid, wdata, D4); end
      vectors++; if (in_ready !== 1'b0 || svalid !== 1'b0) begin errors++; $display("FAIL bp_quiet c%0d got rdy=%b sv=%b exp 0 0", c, in_ready, svalid); end
      smatch = 1'b1;
      tick;
    end
    vectors++; if (wvalid !== 1'b1 || wdata !== D4) begin errors++; $display("FAIL bp_c13 got wv=%b wd=%h exp 1 %h", wvalid, wdata, D4); end
    wready = 1'b1;
    tick;
    vectors++; if (wvalid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_done got wv=%b rdy=%b exp 0 1", wvalid, in_ready); end
    vectors++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL bp_stall got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_reset_mid_wait;
    int leak;
    leak = 0;
    do_reset;
    in_data = D5; in_valid = 1'b1; smatch = 1'b1; wready = 1'b1;
    tick; in_valid = 1'b0; in_data = '0;
    tick; tick; tick;
    vectors++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL rw_pre_stall got %0d exp 2", stall_cnt); end
    rstn = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1 || wvalid !== 1'b0 || svalid !== 1'b0) begin errors++; $display("FAIL rw_async got rdy=%b wv=%b sv=%b exp 1 0 0", in_ready, wvalid, svalid); end
    vectors++; if (wdata !== '0 || sdata !== '0) begin errors++; $display("FAIL rw_async_data got wd=%h sd=%h exp 0 0", wdata, sdata); end
    vectors++; if (stall_cnt !== 16'd0 || hazard_timeout !== 1'b0) begin errors++; $display("FAIL rw_async_cnt got st=%0d hto=%b exp 0 0", stall_cnt, hazard_timeout); end
    tick;
    rstn = 1'b1; smatch = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (wvalid || wdata == D5 || !in_ready) leak++;
    end
    vectors++; if (leak !== 0) begin errors++; $display("FAIL rw_no_push got %0d bad cycles exp 0", leak); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] d [3];
    int idx, np, acc;
    int pc [3];
    logic [DATA_W-1:0] pd [3];
    d[0] = D1; d[1] = D4; d[2] = D5;
    idx = 0; np = 0;
    do_reset;
    smatch = 1'b0; wready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (wvalid && np < 3) begin pc[np] = c; pd[np] = wdata; np++; end
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? d[idx] : '0;
      acc = (in_valid && in_ready) ? 1 : 0;
      tick;
      if (acc == 1) idx++;
    end
    in_valid = 1'b0;
    vectors++; if (np !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", np); end
    for (int i = 0; i < 3; i++) begin
      if (i < np) begin
        vectors++; if (pc[i] !== 3 + 4 * i) begin errors++; $display("FAIL b2b_cycle%0d got %0d exp %0d", i, pc[i], 3 + 4 * i); end
        vectors++; if (pd[i] !== d[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, pd[i], d[i]); end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; smatch = 1'b0; wready = 1'b1;
    test_reset;
    test_no_hazard;
    test_one_hazard;
    test_timeout;
    test_backpressure;
    test_reset_mid_wait;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
